audio_sample_queue: RTL and testbench

AUDIO_SAMPLE_QUEUE -- requirements
Module: audio_sample_queue

---
 rtl/audio_sample_queue.sv | 123 ++++++++++++
 tb/tb_audio_sample_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_queue.sv
// Audio sample queue: captures stereo codec samples, mixes to 16-bit mono,
// and buffers them in a first-word fall-through FIFO for a consumer.
module audio_sample_queue #(
  parameter int DEPTH = 8,
  parameter int LVLW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            codecReadReady,
  input  logic [23:0]     leftIn,
  input  logic [23:0]     rightIn,
  output logic            codecRead,
  output logic            sampleReady,
  input  logic            doingRead,
  output logic [15:0]     sampleOut,
  output logic [LVLW-1:0] level,
  output logic [7:0]      overflowCount
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAITLOW
  } state_t;

  state_t state;

  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_next;
  logic            doing_read_prev;

  logic            push;
  logic            pop;
  logic            accept;
  logic [LVLW-1:0] level_next;
  logic [15:0]     head_next;
  logic [24:0]     sum;
  logic [16:0]     sh;
  logic [15:0]     mixed;

  always_comb begin
    sum = {leftIn[23], leftIn} + {rightIn[23], rightIn};
    sh  = 17'($signed(sum) >>> 8);
    if (sh[16] != sh[15])
      mixed = sh[16] ? 16'h8000 : 16'h7FFF;
    else
      mixed = sh[15:0];
  end

  always_comb begin
    push       = (state == IDLE) && codecReadReady;
    pop        = doingRead && !doing_read_prev && (level != '0);
    accept     = push && ((level < LVLW'(DEPTH)) || pop);
    level_next = level + LVLW'(accept) - LVLW'(pop);
    rd_next    = pop ? AW'(rd_ptr + 1'b1) : rd_ptr;
    // The new head may be the word being written on this very edge.
    if (accept && (wr_ptr == rd_next))
      head_next = mixed;
    else
      head_next = mem[rd_next];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      codecRead <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (codecReadReady) begin
            state     <= ACK;
            codecRead <= 1'b1;
          end
        end
        ACK: begin
          state     <= WAITLOW;
          codecRead <= 1'b0;
        end
        WAITLOW: begin
          if (!codecReadReady)
            state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          codecRead <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= mixed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      doing_read_prev <= 1'b0;
      sampleReady     <= 1'b0;
      sampleOut       <= '0;
      overflowCount   <= '0;
    end else begin
      doing_read_prev <= doingRead;
      level           <= level_next;
      rd_ptr          <= rd_next;
      sampleReady     <= (level_next != '0);
      if (accept)
        wr_ptr <= AW'(wr_ptr + 1'b1);
      if (level_next != '0)
        sampleOut <= head_next;
      if (push && !accept && (overflowCount != 8'hFF))
        overflowCount <= overflowCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_sample_queue.sv
// Directed bench for audio_sample_queue: capture, mix/saturate,
// overflow, full-with-pop, long ready and mid-capture reset.
module tb_audio_sample_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        codecReadReady;
  logic [23:0] leftIn;
  logic [23:0] rightIn;
  logic        codecRead;
  logic        sampleReady;
  logic        doingRead;
  logic [15:0] sampleOut;
  logic [3:0]  level;
  logic [7:0]  overflowCount;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  audio_sample_queue #(.DEPTH(8), .LVLW(4)) dut (
    .clk(clk),
    .rst(rst),
    .codecReadReady(codecReadReady),
    .leftIn(leftIn),
    .rightIn(rightIn),
    .codecRead(codecRead),
    .sampleReady(sampleReady),
    .doingRead(doingRead),
    .sampleOut(sampleOut),
    .level(level),
    .overflowCount(overflowCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (codecRead === 1'b1) pulses = pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [23:0] l, input logic [23:0] r);
    leftIn = l;
    rightIn = r;
    codecReadReady = 1'b1;
    step();
    codecReadReady = 1'b0;
    step();
    step();
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk(tag, sampleOut, exp);
    doingRead = 1'b1;
    step();
    doingRead = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0;
    codecReadReady = 1'b0;
    leftIn = '0;
    rightIn = '0;
    doingRead = 1'b0;
    step();
    step();
    chk("rst_codecRead", codecRead, 0);
    chk("rst_ready", sampleReady, 0);
    chk("rst_out", sampleOut, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflowCount, 0);
    rst = 1'b1;
    step();

    // push then pop with doingRead held
    leftIn = 24'h000100;
    rightIn = 24'h000200;
    codecReadReady = 1'b1;
    step();
    chk("p_codecRead", codecRead, 1);
    chk("p_ready", sampleReady, 1);
    chk("p_out", sampleOut, 16'h0003);
    chk("p_level1", level, 1);
    codecReadReady = 1'b0;
    step();
    chk("p_ack_one", codecRead, 0);
    step();
    doingRead = 1'b1;
    step();
    chk("p_level0", level, 0);
    chk("p_ready0", sampleReady, 0);
    step();
    step();
    step();
    chk("p_hold_level", level, 0);
    chk("p_hold_out", sampleOut, 16'h0003);
    doingRead = 1'b0;
    step();

    // saturation
    capture(24'h7FFFFF, 24'h7FFFFF);
    pop_chk("sat_pos", 16'h7FFF);
    capture(24'h800000, 24'h800000);
    pop_chk("sat_neg", 16'h8000);
    capture(24'h7FFFFF, 24'h800000);
    pop_chk("sat_mix", 16'hFFFF);
    chk("sat_level", level, 0);

    // overflow: ten samples into eight entries
    pulses = 0;
    for (int i = 1; i <= 10; i++)
      capture(24'(i << 8), 24'h0);
    chk("ovf_level", level, 8);
    chk("ovf_count", overflowCount, 2);
    chk("ovf_pulses", pulses, 10);
    chk("ovf_head", sampleOut, 1);

    // full plus simultaneous capture and read
    leftIn = 24'(11 << 8);
    rightIn = '0;
    codecReadReady = 1'b1;
    doingRead = 1'b1;
    step();
    chk("full_level", level, 8);
    chk("full_ovf", overflowCount, 2);
    chk("full_head", sampleOut, 2);
    codecReadReady = 1'b0;
    doingRead = 1'b0;
    step();
    step();
    for (int i = 2; i <= 8; i++)
      pop_chk($sformatf("drain_%0d", i), 16'(i));
    pop_chk("drain_tail", 16'd11);
    chk("drain_level", level, 0);

    // long ready
    pulses = 0;
    leftIn = 24'(5 << 8);
    codecReadReady = 1'b1;
    repeat (20) step();
    codecReadReady = 1'b0;
    step();
    step();
    chk("long_pulses", pulses, 1);
    chk("long_level", level, 1);
    chk("long_out", sampleOut, 5);

    // reset during WAITLOW with three entries
    capture(24'(6 << 8), 24'h0);
    leftIn = 24'(7 << 8);
    codecReadReady = 1'b1;
    step();
    step();
    chk("pre_rst_level", level, 3);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_codecRead", codecRead, 0);
    chk("mid_rst_ready", sampleReady, 0);
    chk("mid_rst_out", sampleOut, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflowCount, 0);
    step();
    rst = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (2) begin
        step();
        if (codecRead === 1'b1) seen = 1'b1;
      end
      chk("post_rst_ack", seen, 1);
    end
    chk("post_rst_level", level, 1);
    chk("post_rst_out", sampleOut, 7);
    codecReadReady = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
